// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and helpers for the synchronous FIFO controller.
package fifo_ctrl_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // Smallest r with 2**r >= v; used to derive the memory address width.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving a dual-port register-file memory with
// one-cycle registered read data. Flags are decoded from the count register
// only, so wr_en/rd_en never reach full/empty combinationally.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              full,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]  mem_wr_data,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]  mem_rd_data
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rd_valid_q, overflow_q, underflow_q;
  logic              push_ok, pop_ok;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Accept decisions; requests seen during reset never strobe the memory.
  always_comb begin
    push_ok = wr_en & ~full & ~rst;
    pop_ok  = rd_en & ~empty & ~rst;
  end

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  // State registers with synchronous reset; error pulses last one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= pop_ok;
      overflow_q  <= wr_en & full;
      underflow_q <= rd_en & empty;
    end
  end

  // Memory port drive and output mapping.
  always_comb begin
    mem_write   = push_ok;
    mem_wr_addr = wr_ptr_q;
    mem_wr_data = wr_data;
    mem_read    = pop_ok;
    mem_rd_addr = rd_ptr_q;
    rd_data     = mem_rd_data;
    rd_valid    = rd_valid_q;
    overflow    = overflow_q;
    underflow   = underflow_q;
    count       = count_q;
  end

endmodule
